sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock FIFO queue, the first-in-first-out counterpart to the team's LIFO stack.
- Same push-side semantics; data leaves from the opposite end of storage, oldest word first.
- Used as an elastic buffer between producer and consumer blocks.
- Valid/ready handshake on both sides; occupancy count and error pulses for system monitoring.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 12, number of storage entries; any value >= 2, not restricted to powers of two.
- CNT_SZ, 4, width of the occupancy count; must satisfy 2^CNT_SZ > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- pushValid  input  1  producer offers pushData this cycle.
- pushData  input  WIDTH  word to enqueue.
- pushReady  output  1  FIFO can accept a word (= !full).
- popValid  output  1  popData holds the oldest word (= !empty).
- popData  output  WIDTH  oldest stored word (show-ahead).
- popReady  input  1  consumer takes popData this cycle.
- count  output  CNT_SZ  current occupancy, 0..DEPTH.
- pushErr  output  1  one-cycle pulse: push attempted while full.
- popErr  output  1  one-cycle pulse: pop attempted while empty.

Behaviour:
- Reset: the single clock is clk; rst is asynchronous and active-high, and clears state immediately regardless of clk.
  - Values during and after reset: wrPtr = rdPtr = 0, count = 0, pushReady = 1, popValid = 0, popData = 0, pushErr = popErr = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words; no partial transfer completes.
- Push accept: pushValid && pushReady at a clk edge.
  - Writes mem[wrPtr] <= pushData.
  - Advances wrPtr by 1, wrapping from DEPTH-1 to 0.
- Pop accept: popValid && popReady at a clk edge.
  - Advances rdPtr by 1, wrapping from DEPTH-1 to 0.
- count update each cycle:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Derived flags: full = (count == DEPTH), empty = (count == 0). Both are decoded from the registered count; no combinational path from inputs.
- popData:
  - Combinational read of mem[rdPtr] when !empty; 0 when empty.
  - Latency from push to popValid = 1 cycle; no bypass from pushData to popData.
- Simultaneous push and pop:
  - When neither full nor empty, both are accepted in the same cycle and count holds.
  - When full, pushReady = 0, so the push is rejected even if a pop occurs that cycle; the producer retries next cycle.
  - When empty, popValid = 0, so the pop is rejected and the push is accepted.
- Error pulses, registered, asserted in the cycle after the offending edge:
  - pushErr <= pushValid && !pushReady.
  - popErr <= popReady && !popValid.
  - Rejected transfers leave pointers, count and memory unchanged.
- Order is strictly FIFO; words are never duplicated or dropped except by reset.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds parameters AFULL_TH (default DEPTH-2) and AEMPTY_TH (default 2).
  - Adds output ports almostFull (count >= AFULL_TH) and almostEmpty (count <= AEMPTY_TH), both decoded from the registered count.
  - Reset values: almostFull = 0, almostEmpty = 1.
- Undefined: these parameters and ports do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default WIDTH/DEPTH constants;
  - a function returning the pointer/count width for a given depth;
  - a typedef for the push/pop handshake bundle, shared with the LIFO wrapper.
- One sub-module, fifo_ptr_ctr: a wrapping modulo-DEPTH pointer register with an increment enable.
  - Instantiated twice, once for wrPtr and once for rdPtr.
- count, flags and error logic stay in sync_fifo.

Test Plan:
- All tests use DEPTH=4, WIDTH=8 unless noted.
- Reset test: assert rst asynchronously mid-cycle after 3 pushes -> count=0, popValid=0, popData=0, pushReady=1 immediately, before the next clk edge.
- Fill and drain: push 0x11,0x22,0x33,0x44 -> count=4, pushReady=0; pop 4 words -> popData sequence 0x11,0x22,0x33,0x44, then popValid=0.
- Overflow: when full, drive pushValid with 0x55 -> pushErr pulses 1 cycle, count stays 4, later pops never return 0x55.
- Underflow: when empty, drive popReady -> popErr pulses 1 cycle, count stays 0.
- Simultaneous push and pop:
  - With count=2, push 0xAA and pop in the same cycle -> count stays 2, popped word is the oldest.
  - When full with pop asserted, the push is rejected and pushErr pulses.
- Wrap-around: 10 interleaved push/pop cycles of 0x01..0x0A -> both pointers wrap past 3, output order is preserved, count never exceeds 4.
- With FIFO_ALMOST_FLAGS_EN defined: almostFull asserts at count=2, almostEmpty deasserts at count=3.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO/LIFO constants, width helper and handshake bundle type
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 12;

    // Smallest width able to address depth entries; never below 1 bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

    typedef struct packed {
        logic valid;
        logic ready;
    } fifo_hs_t;

endpackage

// File: rtl/fifo_ptr_ctr.sv
// rtl/fifo_ptr_ctr.sv - modulo-DEPTH wrapping pointer register with increment enable
module fifo_ptr_ctr #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; FIFO_ALMOST_FLAGS_EN adds almost-full/empty flags
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_SZ = 4
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushValid,
    input  logic [WIDTH-1:0]  pushData,
    output logic              pushReady,
    output logic              popValid,
    output logic [WIDTH-1:0]  popData,
    input  logic              popReady,
    output logic [CNT_SZ-1:0] count,
    output logic              pushErr,
    output logic              popErr
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almostFull,
    output logic              almostEmpty
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;

    // Flags come only from the registered count, so ready/valid never depend on inputs.
    assign full      = (count == CNT_SZ'(DEPTH));
    assign empty     = (count == '0);
    assign pushReady = !full;
    assign popValid  = !empty;
    assign push_acc  = pushValid && !full;
    assign pop_acc   = popReady && !empty;
    assign popData   = empty ? '0 : mem[rd_ptr];

    fifo_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            pushErr <= 1'b0;
            popErr  <= 1'b0;
        end else begin
            if (push_acc && !pop_acc) begin
                count <= count + CNT_SZ'(1);
            end else if (pop_acc && !push_acc) begin
                count <= count - CNT_SZ'(1);
            end
            pushErr <= pushValid && full;
            popErr  <= popReady && empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    assign almostFull  = (count >= CNT_SZ'(AFULL_TH));
    assign almostEmpty = (count <= CNT_SZ'(AEMPTY_TH));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo at DEPTH=4, WIDTH=8
module tb_sync_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready;
    logic [2:0] count;
    logic       push_err;
    logic       pop_err;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    int max_cnt = 0;
    logic [7:0] sb [$];

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CNT_SZ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .pushValid (push_valid),
        .pushData  (push_data),
        .pushReady (push_ready),
        .popValid  (pop_valid),
        .popData   (pop_data),
        .popReady  (pop_ready),
        .count     (count),
        .pushErr   (push_err),
        .popErr    (pop_err)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almostFull  (almost_full),
        .almostEmpty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check pre-edge state against the model, clock, check error pulses.
    task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr);
        logic push_ok;
        logic pop_ok;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        check("count", 32'(count), 32'(model_cnt));
        check("push_ready", 32'(push_ready), 32'(model_cnt != DEPTH));
        check("pop_valid", 32'(pop_valid), 32'(model_cnt != 0));
        if (model_cnt != 0) check("pop_data", 32'(pop_data), 32'(sb[0]));
        else                check("pop_data_empty", 32'(pop_data), 32'h0);
`ifdef FIFO_ALMOST_FLAGS_EN
        check("almost_full", 32'(almost_full), 32'(model_cnt >= 2));
        check("almost_empty", 32'(almost_empty), 32'(model_cnt <= 2));
`endif
        push_ok = pv && (model_cnt < DEPTH);
        pop_ok  = pr && (model_cnt > 0);
        @(posedge clk);
        #1;
        check("push_err", 32'(push_err), 32'(pv && !push_ok));
        check("pop_err", 32'(pop_err), 32'(pr && model_cnt == 0));
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) sb.push_back(pd);
        if (push_ok && !pop_ok) model_cnt++;
        if (pop_ok && !push_ok) model_cnt--;
        if (model_cnt > max_cnt) max_cnt = model_cnt;
    endtask

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_push_ready", 32'(push_ready), 32'h1);
        check("rst_pop_valid", 32'(pop_valid), 32'h0);
        check("rst_pop_data", 32'(pop_data), 32'h0);
        check("rst_errs", 32'({push_err, pop_err}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset mid-cycle after three pushes
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        check("pre_async_count", 32'(count), 32'h3);
        push_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'h0);
        check("async_pop_valid", 32'(pop_valid), 32'h0);
        check("async_pop_data", 32'(pop_data), 32'h0);
        check("async_push_ready", 32'(push_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_cnt = 0;

        // Fill, overflow, full push+pop, drain
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        check("full_count", 32'(count), 32'h4);
        check("full_push_ready", 32'(push_ready), 32'h0);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h66, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("drained_pop_valid", 32'(pop_valid), 32'h0);

        // Underflow, then push+pop while empty
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hBB, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop at count=2
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b1, 8'h88, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        check("simul_count", 32'(count), 32'h2);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Interleaved wrap-around of both pointers
        max_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 8'(i), (i % 3) != 1);
        end
        for (int i = 0; i < 6 && model_cnt > 0; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("wrap_max_count", 32'(max_cnt <= DEPTH), 32'h1);

`ifdef FIFO_ALMOST_FLAGS_EN
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
`endif

        cycle(1'b0, 8'h00, 1'b0);
        check("final_sb_empty", 32'(sb.size()), 32'h0);
        check("final_count", 32'(count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
